// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared size encodings, FSM states and byte-count helper for the LSU memory port
package lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SECOND = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

    // Encoding 3 is treated as a word access.
    function automatic logic [2:0] byte_count(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            default:   return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// rtl/lsu_mem_port_if.sv - request/response and data-memory signal bundle for the LSU memory port
// slave  : LSU side (takes req_*, mem_rdata; drives req_ready, resp_*, mem_*)
// master : pipeline plus memory side (the opposite directions)
interface lsu_mem_port_if #(
    parameter int ADDR_WIDTH = 32
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_misaligned;
    logic [3:0]            mem_byte_enable;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_misaligned,
               mem_byte_enable, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned,
               mem_byte_enable, mem_addr, mem_wdata
    );

endinterface

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - combinational byte-lane mask, store shift and load extract/extend
// off, size, is_unsigned : access offset within the word, size code, zero-extend select
// store_word / load_word  : LSB-aligned store data / raw memory word
// lane_mask[7:0]          : lanes of this word in [3:0], lanes spilling into the next word in [7:4]
// store_shifted           : store data moved up to lane off
// load_ext                : loaded bytes moved down from lane off and extended
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] store_word,
    input  logic [31:0] load_word,
    output logic [7:0]  lane_mask,
    output logic [31:0] store_shifted,
    output logic [31:0] load_ext
);

    logic [3:0]  base_mask;
    logic [31:0] load_sh;

    always_comb begin
        case (byte_count(size))
            3'd1:    base_mask = 4'b0001;
            3'd2:    base_mask = 4'b0011;
            default: base_mask = 4'b1111;
        endcase

        lane_mask     = {4'b0000, base_mask} << off;
        store_shifted = store_word << {off, 3'b000};
        load_sh       = load_word >> {off, 3'b000};

        case (size)
            SIZE_BYTE: load_ext = is_unsigned ? {24'd0, load_sh[7:0]}
                                              : {{24{load_sh[7]}}, load_sh[7:0]};
            SIZE_HALF: load_ext = is_unsigned ? {16'd0, load_sh[15:0]}
                                              : {{16{load_sh[15]}}, load_sh[15:0]};
            default:   load_ext = load_sh;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - LSU data-memory initiator: lane steering, load extension, misaligned split FSM
// clk, rst : clock and synchronous active-high reset
// bus      : lsu_mem_port_if.slave carrying req_*, resp_* and mem_* signals
// LSU_MISALIGNED_SPLIT_EN : when defined, misaligned accesses are split in two word accesses;
//                           otherwise they are answered with resp_misaligned and touch no memory
module lsu_mem_port #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    lsu_mem_port_if.slave bus
);

    import lsu_pkg::*;

`ifdef LSU_MISALIGNED_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    lsu_state_e            state_q, state_d;
    logic [1:0]            off_q, off_d;
    logic [1:0]            size_q, size_d;
    logic                  unsigned_q, unsigned_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            hi_be_q, hi_be_d;
    logic [31:0]           hi_wdata_q, hi_wdata_d;
    logic [31:0]           lo_q, lo_d;
    logic [31:0]           resp_rdata_q, resp_rdata_d;
    logic                  resp_mis_q, resp_mis_d;

    logic [1:0]            al_off;
    logic [1:0]            al_size;
    logic                  al_unsigned;
    logic [31:0]           al_load;
    logic [7:0]            al_mask;
    logic [31:0]           al_wdata;
    logic [31:0]           al_ext;
    logic [31:0]           merged;
    logic                  misaligned;
    logic [ADDR_WIDTH-1:0] req_word;

    // Shared by the first access (request offset) and the second access,
    // where the merged word is already LSB-aligned so offset is 0.
    lsu_lane_align u_align (
        .off           (al_off),
        .size          (al_size),
        .is_unsigned   (al_unsigned),
        .store_word    (bus.req_wdata),
        .load_word     (al_load),
        .lane_mask     (al_mask),
        .store_shifted (al_wdata),
        .load_ext      (al_ext)
    );

    assign req_word        = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
    assign misaligned      = (al_mask[7:4] != 4'b0000);
    // Upper bytes of the second word land just above the bytes latched from the first.
    assign merged          = lo_q | (bus.mem_rdata << {3'd4 - {1'b0, off_q}, 3'b000});
    assign bus.req_ready   = (state_q == IDLE);
    assign bus.resp_valid  = (state_q == RESP) && !rst;
    assign bus.resp_rdata  = resp_rdata_q;
    assign bus.resp_misaligned = resp_mis_q;

    always_comb begin
        state_d      = state_q;
        off_d        = off_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        write_d      = write_q;
        addr_d       = addr_q;
        hi_be_d      = hi_be_q;
        hi_wdata_d   = hi_wdata_q;
        lo_d         = lo_q;
        resp_rdata_d = resp_rdata_q;
        resp_mis_d   = resp_mis_q;
        al_off       = bus.req_addr[1:0];
        al_size      = bus.req_size;
        al_unsigned  = bus.req_unsigned;
        al_load      = bus.mem_rdata;
        bus.mem_byte_enable = 4'b0000;
        bus.mem_addr        = '0;
        bus.mem_wdata       = 32'd0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    bus.mem_addr  = req_word;
                    bus.mem_wdata = al_wdata;
                    if (bus.req_write && (!misaligned || SPLIT_EN))
                        bus.mem_byte_enable = al_mask[3:0];

                    off_d        = bus.req_addr[1:0];
                    size_d       = bus.req_size;
                    unsigned_d   = bus.req_unsigned;
                    write_d      = bus.req_write;
                    addr_d       = req_word + ADDR_WIDTH'(4);
                    hi_be_d      = al_mask[7:4];
                    hi_wdata_d   = bus.req_wdata >> {3'd4 - {1'b0, bus.req_addr[1:0]}, 3'b000};
                    lo_d         = bus.mem_rdata >> {bus.req_addr[1:0], 3'b000};
                    resp_mis_d   = 1'b0;
                    resp_rdata_d = bus.req_write ? 32'd0 : al_ext;
                    state_d      = RESP;
                    if (misaligned) begin
                        if (SPLIT_EN) begin
                            state_d = SECOND;
                        end else begin
                            resp_mis_d   = 1'b1;
                            resp_rdata_d = 32'd0;
                        end
                    end
                end
            end
            SECOND: begin
                bus.mem_addr        = addr_q;
                bus.mem_wdata       = hi_wdata_q;
                bus.mem_byte_enable = write_q ? hi_be_q : 4'b0000;
                al_off       = 2'd0;
                al_size      = size_q;
                al_unsigned  = unsigned_q;
                al_load      = merged;
                resp_rdata_d = write_q ? 32'd0 : al_ext;
                state_d      = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (rst)
            bus.mem_byte_enable = 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            off_q        <= 2'd0;
            size_q       <= 2'd0;
            unsigned_q   <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            hi_be_q      <= 4'b0000;
            hi_wdata_q   <= 32'd0;
            lo_q         <= 32'd0;
            resp_rdata_q <= 32'd0;
            resp_mis_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            off_q        <= off_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            hi_be_q      <= hi_be_d;
            hi_wdata_q   <= hi_wdata_d;
            lo_q         <= lo_d;
            resp_rdata_q <= resp_rdata_d;
            resp_mis_q   <= resp_mis_d;
        end
    end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Initiator side of the data-memory port: accepts load/store requests from the pipeline MEM stage and drives byte_enable/addr/wdata toward the word-addressed, byte-enabled data memory.
- The memory has a combinational read and a synchronous write.
- Generates byte lanes, shifts store data into position, and extracts plus sign/zero-extends load data.
- Splits misaligned accesses into two word accesses under a small FSM; returns one registered response per request.

Parameters:
ADDR_WIDTH, 32, request/memory byte-address width; memory access uses addr[ADDR_WIDTH-1:2], with mem_addr[1:0] always 0

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  high only in IDLE; request accepted when req_valid && req_ready
req_write  input  1  1 = store, 0 = load
req_size  input  2  0 byte, 1 half, 2 word; 3 is treated as word
req_unsigned  input  1  load zero-extends when 1
req_addr  input  ADDR_WIDTH  byte address
req_wdata  input  32  store data, LSB-aligned
resp_valid  output  1  one-cycle pulse, response/ack
resp_rdata  output  32  extended load data; 0 for stores
resp_misaligned  output  1  misaligned fault flag, valid with resp_valid
mem_byte_enable  output  4  write lanes to memory
mem_addr  output  ADDR_WIDTH  word-aligned address
mem_wdata  output  32  lane-shifted store data
mem_rdata  input  32  combinational read data for mem_addr

Behaviour:
- States: IDLE, SECOND, RESP. Reset forces IDLE, resp_valid=0, resp_rdata=0, resp_misaligned=0, all holding registers=0.
- During the reset cycle, mem_byte_enable=0.
- IDLE:
  - Memory outputs are driven combinationally from req_* while req_valid is high; mem_byte_enable=0 when req_valid is low or req_write is low.
  - Let off = req_addr[1:0] and n = 1/2/4 bytes.
  - Aligned case (off+n<=4): lanes off..off+n-1 are enabled for stores; mem_wdata = req_wdata << (8*off). For loads, rdata is captured from mem_rdata, lanes shifted down and extended. Next state is RESP.
  - Misaligned case (off+n>4): the first access covers lanes off..3, with the low bytes of wdata shifted in. For loads, mem_rdata[31:8*off] is latched. The address+4 is latched. Next state is SECOND.
- SECOND:
  - mem_addr = latched word address + 4, wrapping modulo 2^ADDR_WIDTH (0xFFFFFFFC -> 0x00000000).
  - Lanes 0..(off+n-5) carry the remaining store bytes.
  - Loads merge the low bytes of mem_rdata above the latched part, then extend.
  - Next state is RESP.
- RESP: resp_valid=1 for exactly this cycle; next state is IDLE.
- Latency: acceptance at edge T. Aligned: resp_valid in cycle T+1. Split: resp_valid in cycle T+2.
- Throughput: aligned, one request every 2 cycles; split, one every 3.
- No response backpressure: the consumer must sample resp_valid when it pulses.
- Extension: byte and half loads sign-extend from bit 7 or 15 unless req_unsigned; word loads pass through unchanged.
- Stores return resp_rdata=0.
- Request fields are registered at acceptance. Req_* changes after acceptance are ignored.
- Reset asserted in SECOND or RESP: the FSM goes to IDLE and no response is emitted. A first-half store write already committed remains in memory. The second half is not written.

Optional Feature:
- Macro LSU_MISALIGNED_SPLIT_EN.
- Defined: misaligned accesses are split as described above, and resp_misaligned stays 0.
- Undefined: a misaligned request is accepted, but mem_byte_enable stays 0 and no memory is modified. The FSM goes IDLE -> RESP with resp_misaligned=1 and resp_rdata=0. SECOND is unreachable.

Decomposition:
- Package lsu_pkg holds:
  - size encodings SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2;
  - the state enum IDLE/SECOND/RESP;
  - the byte-count function (size -> 1/2/4).
- One natural sub-module, lsu_lane_align: purely combinational. Given offset, size, unsigned and a 32-bit word, it produces the store lane mask, shifted wdata, and extended load data.
- The FSM, latches and the split merge stay in lsu_mem_port.

Test Plan:
- Aligned store: word 0xDEADBEEF @0x100, then load byte unsigned @0x101 -> first request drives be=4'b1111 in the accept cycle; the load responds at T+1 with resp_rdata=0x000000BE.
- Sign extension: memory 0x000080F0 @0x200; load half signed @0x200 -> 0xFFFF80F0; load half unsigned -> 0x000080F0.
- Split store and load (macro defined): store word 0x11223344 @0x103 -> cycle1 be=1000, addr 0x100, wdata[31:24]=0x44; cycle2 be=0111, addr 0x104, wdata[23:0]=0x112233. Load word @0x103 -> 0x11223344 at T+2.
- Wrap: split half store @0xFFFFFFFF with data 0xABCD -> second access uses addr 0x00000000, be=0001, lane data 0xAB.
- Macro undefined: load word @0x102 -> no write lanes enabled, resp at T+1 with resp_misaligned=1 and rdata=0.
- Reset mid-op: assert rst in SECOND of a split store -> no resp_valid, req_ready=1 the next cycle, upper word unchanged.
